// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the receive and transmit paths.
// Build option: UART_RX_FIFO_IRQ_EN enables the receive-FIFO interrupt output.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;
  localparam int UART_RX_FIFO_AW    = 4;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_edge_sync.sv
// Brings a level from a foreign clock domain onto clk and emits a one-cycle
// pulse per rising edge, independent of how long the source level stays high.
module uart_rx_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_pulse
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_pulse = r_s2 & ~r_s3;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: one push per frame-done edge, FWFT pop,
// fill status and a sticky overrun flag. Build option: UART_RX_FIFO_IRQ_EN adds irq.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int DEPTH      = UART_RX_FIFO_DEPTH,
  parameter int ADDR_W     = UART_RX_FIFO_AW
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  parameter int IRQ_THRESH = 1
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              clr_ovr
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [ADDR_W:0]   L_DEPTH   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   L_CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] L_PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overrun;

  logic w_push;
  logic w_pop;
  logic w_wr;
  logic w_drop;
  logic w_empty;
  logic w_full;

  uart_rx_edge_sync u_edge_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rx_ready),
    .o_pulse (w_push)
  );

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == L_DEPTH);

  // A pop frees the head slot in the same edge, so a push into a full FIFO
  // still lands when a valid pop accompanies it.
  assign w_pop  = rd_en & ~w_empty;
  assign w_wr   = w_push & (~w_full | w_pop);
  assign w_drop = w_push & w_full & ~w_pop;

  // rx_data is stable for a whole frame around rx_ready, so it is sampled
  // directly in the push cycle without its own synchroniser.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + L_CNT_ONE;
        2'b01:   r_count <= r_count - L_CNT_ONE;
        default: r_count <= r_count;
      endcase
      // Set has priority so a drop coinciding with a clear is not lost.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_ovr) begin
        r_overrun <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  localparam logic [ADDR_W:0] L_IRQ_THRESH = (ADDR_W+1)'(IRQ_THRESH);

  logic r_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_count >= L_IRQ_THRESH) | r_overrun;
    end
  end

  assign irq = r_irq;
`endif

  assign rd_data = r_mem[r_rd_ptr];
  assign empty   = w_empty;
  assign full    = w_full;
  assign count   = r_count;
  assign overrun = r_overrun;

endmodule
